// File: rtl/ex_wb_stage.sv
// ex_wb_stage: ALU writeback buffer (2-entry FIFO), flag register and decode hazard check.
// Optional EX_WB_STALL_CNT_EN adds a saturating writeback stall counter.
module ex_wb_stage #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_sc_o,
    input  logic          alu_pari,
    input  logic          alu_zero,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          upd_flags,
    input  logic          carry_clr,
    output logic          sc_q,
    output logic          zero_q,
    output logic          pari_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    input  logic [AW-1:0] chk_addr,
`ifdef EX_WB_STALL_CNT_EN
    input  logic          stall_clr,
    output logic [15:0]   stall_cnt,
`endif
    output logic          chk_hit
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_n;
    logic accept, enq, pop;
    logic [DW-1:0] d1;
    logic [AW-1:0] a1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else state <= state_n;
    always_comb begin
        in_ready  = state != TWO;
        out_valid = state != EMPTY;
        accept    = in_valid && in_ready;
        enq       = accept && wr_en;
        pop       = out_valid && out_ready;
        state_n   = state == EMPTY ? (enq ? ONE : EMPTY) :
                    state == ONE   ? (enq && !pop ? TWO : pop && !enq ? EMPTY : ONE) :
                                     (pop ? ONE : TWO);
        chk_hit   = (state != EMPTY && out_addr == chk_addr) || (state == TWO && a1 == chk_addr);
    end
    // Entry 0 is always the head; entry 1 shifts into it on pop from TWO.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_data <= '0;
            out_addr <= '0;
            d1       <= '0;
            a1       <= '0;
        end else begin
            if (pop && state == TWO) begin
                out_data <= d1;
                out_addr <= a1;
            end else if (enq && (state == EMPTY || pop)) begin
                out_data <= alu_rslt;
                out_addr <= wr_addr;
            end
            if (enq && state == ONE && !pop) begin
                d1 <= alu_rslt;
                a1 <= wr_addr;
            end
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sc_q   <= 1'b0;
            zero_q <= 1'b0;
            pari_q <= 1'b0;
        end else if (accept && upd_flags) begin
            sc_q   <= carry_clr ? 1'b0 : alu_sc_o;
            zero_q <= alu_zero;
            pari_q <= alu_pari;
        end
`ifdef EX_WB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stall_cnt <= '0;
        else if (stall_clr) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed self-checking bench for ex_wb_stage (stall counter checks with EX_WB_STALL_CNT_EN).
module tb_ex_wb_stage;
    logic clk = 1'b0, rst_n = 1'b1;
    logic in_valid = 0, in_ready, alu_sc_o = 0, alu_pari = 0, alu_zero = 0, wr_en = 0, upd_flags = 0, carry_clr = 0;
    logic sc_q, zero_q, pari_q, out_valid, out_ready = 0, chk_hit;
    logic [7:0] alu_rslt = 0, out_data;
    logic [3:0] wr_addr = 0, out_addr, chk_addr = 0;
    int n_chk = 0, n_fail = 0;
`ifdef EX_WB_STALL_CNT_EN
    logic stall_clr = 0;
    logic [15:0] stall_cnt;
`endif
    ex_wb_stage #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_pari(alu_pari), .alu_zero(alu_zero),
        .wr_en(wr_en), .wr_addr(wr_addr), .upd_flags(upd_flags), .carry_clr(carry_clr),
        .sc_q(sc_q), .zero_q(zero_q), .pari_q(pari_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .chk_addr(chk_addr),
`ifdef EX_WB_STALL_CNT_EN
        .stall_clr(stall_clr), .stall_cnt(stall_cnt),
`endif
        .chk_hit(chk_hit)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic op(input logic [3:0] a, input logic [7:0] d);
        in_valid = 1; wr_en = 1; wr_addr = a; alu_rslt = d;
    endtask
    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 1);
        chk("rst_sc", sc_q, 0); chk("rst_zero", zero_q, 0); chk("rst_pari", pari_q, 0);
        chk("rst_data", out_data, 0); chk("rst_addr", out_addr, 0); chk("rst_hit", chk_hit, 0);
        #9 rst_n = 1;
        // single write passes straight through
        op(3, 8'hA5); out_ready = 1;
        step();
        chk("t1_valid", out_valid, 1); chk("t1_data", out_data, 8'hA5); chk("t1_addr", out_addr, 3);
        in_valid = 0;
        step();
        chk("t1_empty", out_valid, 0); chk("t1_ready", in_ready, 1);
        // backpressure fills the buffer; order and hazard check
        out_ready = 0; op(1, 8'h11);
        step();
        chk("t2_ready1", in_ready, 1); chk("t2_head1", out_data, 8'h11);
        op(2, 8'h22);
        step();
        chk("t2_full", in_ready, 0);
        op(5, 8'h55);
        step();
        chk("t2_still_full", in_ready, 0); chk("t2_hold_data", out_data, 8'h11); chk("t2_hold_addr", out_addr, 1);
        chk_addr = 2; #1 chk("hit_2", chk_hit, 1);
        chk_addr = 5; #1 chk("hit_5", chk_hit, 0);
        chk_addr = 1; #1 chk("hit_head", chk_hit, 1);
        out_ready = 1;
        step();
        chk("t2_second", out_data, 8'h22); chk("t2_second_addr", out_addr, 2); chk("t2_ready2", in_ready, 1);
        step();
        chk("t2_third", out_data, 8'h55); chk("t2_third_addr", out_addr, 5); chk("t2_third_valid", out_valid, 1);
        in_valid = 0;
        step();
        chk("t2_drained", out_valid, 0);
        // flag chain
        in_valid = 1; wr_en = 0; upd_flags = 1; alu_sc_o = 1; alu_zero = 1; alu_pari = 1;
        step();
        chk("f1_sc", sc_q, 1); chk("f1_zero", zero_q, 1); chk("f1_pari", pari_q, 1); chk("f1_noenq", out_valid, 0);
        carry_clr = 1; alu_zero = 0; alu_pari = 0;
        step();
        chk("f2_sc", sc_q, 0); chk("f2_zero", zero_q, 0); chk("f2_pari", pari_q, 0);
        upd_flags = 0; carry_clr = 0; alu_zero = 1;
        step();
        chk("f3_sc", sc_q, 0); chk("f3_zero", zero_q, 0);
        // stalled op must not touch flags
        out_ready = 0; op(8, 8'h80); upd_flags = 1; alu_sc_o = 1; alu_zero = 1; alu_pari = 0;
        step();
        chk("f4_sc", sc_q, 1); chk("f4_zero", zero_q, 1);
        op(9, 8'h90); upd_flags = 0;
        step();
        chk("f5_full", in_ready, 0);
        upd_flags = 1; carry_clr = 1; alu_zero = 0;
        step();
        chk("f6_stall_sc", sc_q, 1); chk("f6_stall_zero", zero_q, 1);
        in_valid = 0; upd_flags = 0; carry_clr = 0; out_ready = 1;
        step();
        chk("f7_head", out_data, 8'h90);
        step();
        chk("f7_empty", out_valid, 0);
        // simultaneous pop and enqueue in ONE
        out_ready = 0; op(6, 8'h66);
        step();
        chk("t4_head", out_data, 8'h66);
        out_ready = 1; op(7, 8'h3C);
        step();
        chk("t4_valid", out_valid, 1); chk("t4_ready", in_ready, 1);
        chk("t4_data", out_data, 8'h3C); chk("t4_addr", out_addr, 7);
        in_valid = 0;
        step();
        chk("t4_empty", out_valid, 0);
`ifdef EX_WB_STALL_CNT_EN
        out_ready = 0; op(1, 8'h01);
        step();
        in_valid = 0;
        chk("sc_start", stall_cnt, 0);
        repeat (5) step();
        chk("sc_five", stall_cnt, 5);
        stall_clr = 1;
        step();
        chk("sc_clr", stall_cnt, 0);
        stall_clr = 0; out_ready = 1;
        step();
        chk("sc_drained", out_valid, 0);
`endif
        // asynchronous reset with two entries buffered
        out_ready = 0; op(4, 8'h44); upd_flags = 1; alu_sc_o = 1;
        step();
        op(5, 8'h55); upd_flags = 0;
        step();
        in_valid = 0; chk_addr = 4;
        #1;
        chk("t5_full", in_ready, 0); chk("t5_sc", sc_q, 1); chk("t5_hit", chk_hit, 1);
        #1 rst_n = 0;
        #1;
        chk("t5_valid", out_valid, 0); chk("t5_sc0", sc_q, 0); chk("t5_hit0", chk_hit, 0);
        chk("t5_ready", in_ready, 1); chk("t5_data", out_data, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Sits directly downstream of the combinational 8-bit ALU.
- Captures the ALU result and flag outputs into a 2-entry register-file writeback buffer.
- Holds the architectural flag register. Its carry bit feeds the ALU `sc_i` input back, so chained multi-byte add/sub/shift ops work across consecutive instructions.
- Provides a hazard check so decode can stall on a register whose write is still pending.

Parameters:
- DW, 8, datapath width; must match the ALU.
- AW, 4, register-file address width (16 registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  the ALU op this cycle is complete and its outputs are stable.
- in_ready  out  1  stage can accept the op.
- alu_rslt  in  DW  ALU `rslt`.
- alu_sc_o  in  1  ALU shift/carry out.
- alu_pari  in  1  ALU parity.
- alu_zero  in  1  ALU zero.
- wr_en  in  1  op writes a register.
- wr_addr  in  AW  destination register.
- upd_flags  in  1  op updates the flag register.
- carry_clr  in  1  force the carry flag to 0 (takes priority over alu_sc_o).
- sc_q  out  1  carry flag; drives ALU `sc_i`.
- zero_q  out  1  zero flag.
- pari_q  out  1  parity flag.
- out_valid  out  1  writeback entry presented to the register file.
- out_ready  in  1  register file accepts the write.
- out_data  out  DW  write data (head entry).
- out_addr  out  AW  write address (head entry).
- chk_addr  in  AW  register address queried by decode.
- chk_hit  out  1  a buffered (not yet written) entry targets chk_addr.

Behaviour:
- Reset (async assert, sync-safe deassert): occupancy 0; sc_q, zero_q, pari_q = 0; out_valid 0; out_data 0; out_addr 0; chk_hit 0; in_ready 1.
- Occupancy FSM states:
  - EMPTY (0 entries).
  - ONE (1 entry).
  - TWO (2 entries).
- Handshake signals:
  - in_ready = (state != TWO). It is registered-state based, with no combinational path from out_ready.
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = (state != EMPTY).
- Enqueue: on accept with wr_en=1, alu_rslt and wr_addr are written to the tail entry. On accept with wr_en=0, nothing is enqueued and the accept is still legal.
- State transitions:
  - EMPTY: enqueue -> ONE.
  - ONE: enqueue & !pop -> TWO; pop & !enqueue -> EMPTY; enqueue & pop -> ONE (new entry becomes head next cycle); otherwise hold.
  - TWO: pop -> ONE (second entry becomes head); no enqueue possible.
- Ordering: strictly FIFO. out_data and out_addr come from registers, are stable while out_valid & !out_ready, and must not change until pop.
- Flag update: on accept with upd_flags=1, in the same edge:
  - sc_q <= carry_clr ? 0 : alu_sc_o.
  - zero_q <= alu_zero.
  - pari_q <= alu_pari.
  - Flags update even when wr_en=0 and independent of writeback-buffer backpressure.
  - Without upd_flags, flags hold. carry_clr without upd_flags is ignored.
- Flag timing: sc_q is visible to the ALU on the cycle after accept, so back-to-back chained ops see the correct carry.
- No accept while in_ready=0. An op stalled upstream must not affect the flags.
- Hazard check: chk_hit is combinational. It is high if any occupied entry's addr == chk_addr. It includes the head entry in its pop cycle (conservative), and excludes the in-flight input op.
- Data values: any DW value is passed unmodified. Address wrap is not applicable. Buffer depth is fixed at 2.
- Reset mid-operation: buffered writes are discarded, not written; flags clear immediately.

Optional Feature:
- Macro: EX_WB_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt (16 bits), reset 0.
  - Increments each cycle that out_valid & !out_ready; saturates at 16'hFFFF.
  - Adds input port stall_clr (1 bit), which synchronously zeroes the counter. stall_clr takes priority over increment.
- When undefined: the ports and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid=1, wr_en=1, wr_addr=3, alu_rslt=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_addr=3; the following cycle state is EMPTY.
- out_ready=0; three ops (addr 1 data 11, addr 2 data 22, addr 5 data 55) -> first two accepted, in_ready=0 on the third cycle. Then chk_addr=2 gives chk_hit=1 and chk_addr=5 gives chk_hit=0. After out_ready=1, writes emerge in order 11, 22, then 55 once accepted.
- Chained add: op1 upd_flags=1, alu_sc_o=1, alu_zero=1 -> next cycle sc_q=1, zero_q=1. op2 with upd_flags=1, carry_clr=1 -> sc_q=0. op3 with upd_flags=0, alu_sc_o=1 -> sc_q stays 0.
- In state ONE with out_ready=1 and a simultaneous enqueue of (addr 7, data 3C) -> state remains ONE and the head becomes 7/3C the next cycle.
- Two entries buffered, assert rst_n=0 mid-cycle -> out_valid, sc_q and chk_hit are 0 immediately, with no clock edge.
- With EX_WB_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. Then stall_clr=1 -> 0.
